// File: rtl/rd_multi_ch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rd_multi_ch_arbiter
// Brief    : Round-robin burst arbiter over NUM_CH FIFO read ports, merging
//            the returned words into one tagged valid/ready stream.
// Revision : 1.0
// ============================================================================
module rd_multi_ch_arbiter #(
    parameter int DATASIZE  = 8,
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = 8,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int BL_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic [NUM_CH-1:0]          rd_empty,
    input  logic [NUM_CH*DATASIZE-1:0] odata,
    output logic [NUM_CH-1:0]          rden,
    input  logic [BL_W-1:0]            burst_len,
    output logic [DATASIZE-1:0]        m_data,
    output logic [CH_W-1:0]            m_ch,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       busy
);

    localparam logic       IDLE  = 1'b0;
    localparam logic       BURST = 1'b1;
    localparam logic [BL_W-1:0] BMAX    = BL_W'(BURST_MAX);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic                state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [BL_W-1:0]     rem_q, rem_d;
    logic                inflight_q, inflight_d;
    logic [CH_W-1:0]     inflight_ch_q, inflight_ch_d;
    logic [1:0]          occ_q, occ_d;
    logic [DATASIZE-1:0] buf_data_q [2];
    logic [DATASIZE-1:0] buf_data_d [2];
    logic [CH_W-1:0]     buf_ch_q [2];
    logic [CH_W-1:0]     buf_ch_d [2];

    logic                pop;
    logic                issue;
    logic                credit_ok;
    logic [2:0]          need;
    logic                any_ne;
    logic [CH_W-1:0]     sel;
    logic [CH_W-1:0]     nxt_ptr;
    logic [1:0]          occ_t;
    logic [DATASIZE-1:0] cap_word;
    int                  srch_idx;

    assign pop       = m_valid && m_ready;
    assign need      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (need < 3'd2);
    assign nxt_ptr   = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
    assign cap_word  = odata[int'(inflight_ch_q) * DATASIZE +: DATASIZE];

    // Cyclic search from ptr: walk offsets high to low so the nearest wins.
    always_comb begin
        any_ne   = 1'b0;
        sel      = '0;
        srch_idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            srch_idx = int'(ptr_q) + k;
            if (srch_idx >= NUM_CH) srch_idx = srch_idx - NUM_CH;
            if (!rd_empty[srch_idx[CH_W-1:0]]) begin
                any_ne = 1'b1;
                sel    = srch_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_ne) begin
                    state_d = BURST;
                    grant_d = sel;
                    if (burst_len == '0)       rem_d = BL_W'(1);
                    else if (burst_len > BMAX) rem_d = BMAX;
                    else                       rem_d = burst_len;
                end
            end
            BURST: begin
                if (rd_empty[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    rem_d = (rem_q == '0) ? '0 : rem_q - 1'b1;
                    if (rem_q <= BL_W'(1)) begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A read during the reset cycle would be lost anyway, so never issue one.
    assign rden          = (issue && !rrst) ? (NUM_CH'(1) << grant_q) : '0;
    assign inflight_d    = issue && !rrst;
    assign inflight_ch_d = grant_q;

    // Pop shifts the head out first, then the returning word lands behind it.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_ch_d   = buf_ch_q;
        occ_t      = occ_q;
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_ch_d[0]   = buf_ch_q[1];
            occ_t         = occ_q - 2'd1;
        end
        if (inflight_q) begin
            if (occ_t == 2'd0) begin
                buf_data_d[0] = cap_word;
                buf_ch_d[0]   = inflight_ch_q;
            end else begin
                buf_data_d[1] = cap_word;
                buf_ch_d[1]   = inflight_ch_q;
            end
            occ_t = occ_t + 2'd1;
        end
        occ_d = occ_t;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            rem_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_ch_q <= '0;
            occ_q         <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_ch_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            rem_q         <= rem_d;
            inflight_q    <= inflight_d;
            inflight_ch_q <= inflight_ch_d;
            occ_q         <= occ_d;
            buf_data_q    <= buf_data_d;
            buf_ch_q      <= buf_ch_d;
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf_data_q[0];
    assign m_ch    = buf_ch_q[0];
    assign busy    = (state_q == BURST) || (occ_q != 2'd0) || inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_multi_ch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_multi_ch_arbiter
// Brief    : Queue-based FIFO models and a burst-level round-robin model for
//            rd_multi_ch_arbiter, with directed and randomized phases.
// Revision : 1.0
// ============================================================================
module tb_rd_multi_ch_arbiter;

    localparam int DATASIZE  = 8;
    localparam int NUM_CH    = 4;
    localparam int BURST_MAX = 8;
    localparam int CH_W      = $clog2(NUM_CH);
    localparam int BL_W      = $clog2(BURST_MAX + 1);

    logic                       rclk      = 1'b0;
    logic                       rrst      = 1'b1;
    logic [NUM_CH-1:0]          rd_empty  = '1;
    logic [NUM_CH*DATASIZE-1:0] odata     = '0;
    logic [NUM_CH-1:0]          rden;
    logic [BL_W-1:0]            burst_len = '0;
    logic [DATASIZE-1:0]        m_data;
    logic [CH_W-1:0]            m_ch;
    logic                       m_valid;
    logic                       m_ready   = 1'b0;
    logic                       busy;

    rd_multi_ch_arbiter #(
        .DATASIZE (DATASIZE),
        .NUM_CH   (NUM_CH),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rd_empty (rd_empty),
        .odata    (odata),
        .rden     (rden),
        .burst_len(burst_len),
        .m_data   (m_data),
        .m_ch     (m_ch),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    always #5 rclk = ~rclk;

    int unsigned       fq [NUM_CH][$];
    int unsigned       exp_q [$];
    int                acc_cyc [$];
    int                m_ptr     = 0;
    int                n_checks  = 0;
    int                n_pass    = 0;
    int                cyc       = 0;
    int                rden_cnt  = 0;
    int                rdy_mode  = 1;
    bit                mon_en    = 1'b0;
    bit                chk_en    = 1'b0;
    bit                hold      = 1'b0;
    logic [DATASIZE-1:0] hold_d  = '0;
    logic [CH_W-1:0]     hold_c  = '0;
    logic [NUM_CH-1:0]   rden_n  = '0;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    // Registered-read FIFOs: word appears on odata the cycle after rden.
    always @(posedge rclk) begin
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rden_n[i] && fq[i].size() > 0)
                odata[i*DATASIZE +: DATASIZE] <= DATASIZE'(fq[i].pop_front());
            rd_empty[i] <= (fq[i].size() == 0);
        end
    end

    always @(negedge rclk) begin
        rden_n = rden;
        if (mon_en) begin
            chk("rden_onehot0", ($countones(rden) <= 1), 1);
            chk("rden_nonempty", rden & rd_empty, 0);
            if (|rden) rden_cnt++;
            if (hold && !rrst) begin
                chk("hold_data", m_data, hold_d);
                chk("hold_ch", m_ch, hold_c);
            end
            hold   = m_valid && !m_ready && !rrst;
            hold_d = m_data;
            hold_c = m_ch;
            if (m_valid && m_ready && !rrst && chk_en) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {m_ch, m_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("beat", {m_ch, m_data}, exp_q.pop_front());
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    // Burst-level model: walk channels from the pointer, take up to the
    // clamped burst length from each, advance the pointer past it.
    function automatic void predict(input int unsigned bl);
        int taken [NUM_CH];
        int n;
        int c;
        int take;
        n = (bl == 0) ? 1 : ((bl > BURST_MAX) ? BURST_MAX : int'(bl));
        for (int i = 0; i < NUM_CH; i++) taken[i] = 0;
        while (1) begin
            c = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_CH;
                if (c < 0 && fq[idx].size() > taken[idx]) c = idx;
            end
            if (c < 0) break;
            take = fq[c].size() - taken[c];
            if (take > n) take = n;
            for (int j = 0; j < take; j++)
                exp_q.push_back((c << DATASIZE) | fq[c][taken[c] + j]);
            taken[c] += take;
            m_ptr = (c + 1) % NUM_CH;
        end
    endfunction

    task automatic load(input int ch, input int n, input int base);
        for (int j = 0; j < n; j++) fq[ch].push_back((base + j) & 8'hFF);
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic do_reset();
        rrst  = 1'b1;
        m_ptr = 0;
        step();
        step();
        rrst  = 1'b0;
    endtask

    task automatic run_phase(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_in_time"}, (n < budget), 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        // Reset with every channel non-empty; first grant must be ch0.
        rdy_mode = 1;
        m_ready  = 1'b1;
        mon_en   = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) load(ch, 1, 8'h10 + ch);
        step();
        step();
        chk("rst_rden", rden, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ch", m_ch, 0);
        m_ptr     = 0;
        burst_len = 1;
        predict(1);
        chk_en = 1'b1;
        rrst   = 1'b0;
        n = 0;
        while (!(|rden) && n < 20) begin step(); n++; end
        chk("first_grant", rden, 4'b0001);
        run_phase("rst_rr", 200);

        // Single burst from ch2, then ch3 must get the next grant.
        do_reset();
        burst_len = 4;
        load(2, 6, 8'hA0);
        load(3, 1, 8'h55);
        predict(4);
        acc_cyc.delete();
        run_phase("single", 200);
        chk("single_beats", acc_cyc.size(), 7);
        if (acc_cyc.size() >= 4) chk("single_consec", acc_cyc[3] - acc_cyc[0], 3);

        // Round robin with one word per grant.
        do_reset();
        burst_len = 1;
        for (int ch = 0; ch < NUM_CH; ch++) load(ch, 2, 8'h20 + 2 * ch);
        predict(1);
        run_phase("rr", 200);

        // Backpressure: only two reads fit while the consumer stalls.
        do_reset();
        rdy_mode  = 0;
        m_ready   = 1'b0;
        burst_len = 8;
        load(0, 8, 8'h80);
        predict(8);
        rden_cnt = 0;
        repeat (12) step();
        chk("bp_rden", rden_cnt, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 8'h80);
        rdy_mode = 1;
        run_phase("bp", 200);

        // Early empty ends the burst; then burst_len=0 gives one read per grant.
        do_reset();
        burst_len = 6;
        load(1, 3, 8'h30);
        predict(6);
        rden_cnt = 0;
        run_phase("early", 200);
        chk("early_rden", rden_cnt, 3);
        burst_len = 0;
        load(0, 2, 8'h40);
        load(2, 2, 8'h50);
        predict(0);
        rden_cnt = 0;
        run_phase("bl0", 200);
        chk("bl0_rden", rden_cnt, 4);

        // Reset one cycle after the 2nd read of a burst.
        do_reset();
        burst_len = 6;
        load(1, 6, 8'h60);
        chk_en   = 1'b0;
        rden_cnt = 0;
        n = 0;
        while (rden_cnt < 2 && n < 50) begin step(); n++; end
        chk("mid_reach", (rden_cnt >= 2), 1);
        rrst  = 1'b1;
        m_ptr = 0;
        load(0, 2, 8'h70);
        step();
        step();
        chk("mid_rst_valid", m_valid, 0);
        predict(6);
        chk_en = 1'b1;
        rrst   = 1'b0;
        step();
        chk("mid_post_valid", m_valid, 0);
        run_phase("mid", 200);

        // Randomized contents, burst lengths (including above BURST_MAX) and ready.
        rdy_mode = 2;
        for (int it = 0; it < 8; it++) begin
            burst_len = BL_W'($urandom_range(0, 12));
            for (int ch = 0; ch < NUM_CH; ch++)
                load(ch, $urandom_range(0, 5), $urandom_range(0, 255));
            predict(burst_len);
            run_phase("rand", 600);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
